// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ahb_pkg
// Purpose  : Shared AHB encodings and the default-slave state type for the
//            LCD-subsystem response multiplexer.
// Revision : 1.0 - initial release
// ============================================================================
package ahb_pkg;

    localparam int AHB_NUM_SLV = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        OKAY  = 2'b00,
        ERROR = 2'b01,
        RETRY = 2'b10,
        SPLIT = 2'b11
    } hresp_t;

    typedef enum logic [1:0] {
        OK   = 2'b00,
        ERR1 = 2'b01,
        ERR2 = 2'b10
    } default_st_t;

endpackage : ahb_pkg
`default_nettype wire

// File: rtl/ahb_default_slave.sv
`default_nettype none
// ============================================================================
// Module   : ahb_default_slave
// Purpose  : Two-cycle AHB ERROR responder for transfers that address no
//            valid slave.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       active,
    output logic       ds_hready,
    output logic [1:0] ds_hresp
);

    default_st_t r_state;
    default_st_t w_state;

    // The first data-phase cycle of an unmapped transfer is already ERR1, so
    // the wait state appears with zero latency; the register tracks ERR2.
    always_comb begin
        w_state = r_state;
        if ((r_state == OK) && active) begin
            w_state = ERR1;
        end
    end

    always_comb begin
        ds_hready = (w_state != ERR1);
        ds_hresp  = (w_state == OK) ? OKAY : ERROR;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state <= OK;
        end else begin
            case (w_state)
                OK:      r_state <= OK;
                ERR1:    r_state <= ERR2;
                ERR2:    r_state <= OK;
                default: r_state <= OK;
            endcase
        end
    end

endmodule : ahb_default_slave
`default_nettype wire

// File: rtl/ahb_slave_mux.sv
`default_nettype none
// ============================================================================
// Module   : ahb_slave_mux
// Purpose  : AHB data-phase response multiplexer for the LCD subsystem;
//            registers HSEL in the address phase and routes the selected
//            slave's HRDATA/HREADYOUT/HRESP back to the master.
//            Define AHB_DEFAULT_SLV_EN to add the ERROR-responding default
//            slave for unmapped or multi-hot selects.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_slave_mux
    import ahb_pkg::*;
#(
    parameter int NUM_SLV = AHB_NUM_SLV,
    parameter int DATA_W  = 32
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [NUM_SLV-1:0]        HSEL,
    input  logic [1:0]                HTRANS,
    input  logic [NUM_SLV*DATA_W-1:0] HRDATA_S,
    input  logic [NUM_SLV-1:0]        HREADYOUT_S,
    input  logic [2*NUM_SLV-1:0]      HRESP_S,
    output logic [DATA_W-1:0]         HRDATA,
    output logic                      HREADY,
    output logic [1:0]                HRESP,
    output logic [NUM_SLV-1:0]        DSEL
);

    logic [NUM_SLV-1:0] r_dsel;
    logic               r_dtrans;
    logic               w_hready;
    logic               w_addr_xfer;
    htrans_t            w_htrans;

    logic [DATA_W-1:0]  w_rdata_s [NUM_SLV];
    logic [1:0]         w_resp_s  [NUM_SLV];

    logic [DATA_W-1:0]  w_pri_rdata;
    logic               w_pri_ready;
    logic [1:0]         w_pri_resp;

    generate
        for (genvar g = 0; g < NUM_SLV; g++) begin : g_slv
            assign w_rdata_s[g] = HRDATA_S[g*DATA_W +: DATA_W];
            assign w_resp_s[g]  = HRESP_S[2*g +: 2];
        end
    endgenerate

    assign w_htrans    = htrans_t'(HTRANS);
    assign w_addr_xfer = (w_htrans == NONSEQ) || (w_htrans == SEQ);

    // Address phase only completes while the bus is ready.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_dsel   <= '0;
            r_dtrans <= 1'b0;
        end else if (w_hready) begin
            r_dsel   <= HSEL;
            r_dtrans <= w_addr_xfer;
        end
    end

    // Descending scan so the lowest set index is the final winner.
    always_comb begin
        w_pri_rdata = '0;
        w_pri_ready = 1'b1;
        w_pri_resp  = OKAY;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if (r_dsel[i]) begin
                w_pri_rdata = w_rdata_s[i];
                w_pri_ready = HREADYOUT_S[i];
                w_pri_resp  = w_resp_s[i];
            end
        end
    end

`ifdef AHB_DEFAULT_SLV_EN
    logic       w_valid;
    logic       w_ds_active;
    logic       w_ds_hready;
    logic [1:0] w_ds_hresp;

    assign w_valid     = $onehot(r_dsel);
    assign w_ds_active = !w_valid && r_dtrans;

    ahb_default_slave u_default_slave (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .active    (w_ds_active),
        .ds_hready (w_ds_hready),
        .ds_hresp  (w_ds_hresp)
    );

    always_comb begin
        HRDATA   = '0;
        w_hready = w_ds_hready;
        HRESP    = w_ds_hresp;
        if (w_valid) begin
            HRDATA   = w_pri_rdata;
            w_hready = w_pri_ready;
            HRESP    = w_pri_resp;
        end
    end
`else
    logic w_unused_dtrans;

    assign w_unused_dtrans = r_dtrans;

    always_comb begin
        HRDATA   = w_pri_rdata;
        w_hready = w_pri_ready;
        HRESP    = w_pri_resp;
    end
`endif

    assign HREADY = w_hready;
    assign DSEL   = r_dsel;

endmodule : ahb_slave_mux
`default_nettype wire

// File: doc/ahb_slave_mux.md
Name: ahb_slave_mux

Overview:
- AHB data-phase response multiplexer sitting directly downstream of the LCD-subsystem address decoder.
- Registers the decoder's one-hot HSEL during the address phase.
- Uses that registered select in the data phase to route HRDATA/HREADY/HRESP from the addressed LCD controller slave back to the master.
- Drives the bus-wide HREADY fed back to all slaves and to itself.

Parameters:
- NUM_SLV, 5, number of slave ports; matches decoder HSEL width.
- DATA_W, 32, read data width.

Ports:
- HCLK  in  1  bus clock
- HRESET  in  1  asynchronous active-high reset
- HSEL  in  NUM_SLV  one-hot slave select from decoder (address phase)
- HTRANS  in  2  transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- HRDATA_S  in  NUM_SLV*DATA_W  slave read data; slave i at bits [i*DATA_W +: DATA_W]
- HREADYOUT_S  in  NUM_SLV  per-slave ready
- HRESP_S  in  2*NUM_SLV  per-slave response; slave i at [2i+1:2i]
- HRDATA  out  DATA_W  muxed read data to master
- HREADY  out  1  global ready; also broadcast to slaves
- HRESP  out  2  muxed response: OKAY=00, ERROR=01, RETRY=10, SPLIT=11
- DSEL  out  NUM_SLV  registered data-phase select (observability)

Behaviour:
- Clocking and reset: one clock HCLK; reset HRESET is asynchronous and active-high.
- Reset values: DSEL=0, dtrans (registered HTRANS[1])=0, FSM=OK. Consequently HREADY=1, HRESP=OKAY, HRDATA=0.
- Address-phase capture: on HCLK rising edge with HREADY=1, DSEL<=HSEL and dtrans<=HTRANS[1]. With HREADY=0, both hold.
- Valid DSEL (exactly one bit set): outputs are purely combinational from DSEL.
  - HRDATA=HRDATA_S[k], HREADY=HREADYOUT_S[k], HRESP=HRESP_S[k].
  - Zero added latency; slave wait states pass straight through.
- DSEL=0:
  - HREADY=1, HRESP=OKAY, HRDATA=0.
  - Subject to the default-slave rule when the feature is compiled in.
- Multi-hot DSEL, feature out: lowest set index wins.
- Multi-hot DSEL, feature in: treated as invalid (default slave).
- HRDATA is driven 0 whenever no valid slave is selected. It is never X.
- Back-to-back transfers: a new HSEL captured while the current slave asserts HREADYOUT=1 switches the mux in the next cycle with no bubble.
- Reset mid-transfer (including mid-error sequence): immediate return to reset values; no ERROR cycles are emitted.

Optional Feature:
- Macro: AHB_DEFAULT_SLV_EN.
- With AHB_DEFAULT_SLV_EN defined, an internal default slave is active. FSM states: OK, ERR1, ERR2.
  - OK -> ERR1 when DSEL is invalid (zero or multi-hot) and dtrans=1 (NONSEQ/SEQ) in data phase.
  - ERR1: HREADY=0, HRESP=ERROR; next state ERR2. DSEL holds because HREADY=0.
  - ERR2: HREADY=1, HRESP=ERROR; next state OK. The next address phase is captured in this cycle.
  - Invalid DSEL with dtrans=0 (IDLE/BUSY): HREADY=1, OKAY, zero wait.
- Without the macro: no FSM; invalid/zero DSEL always gives HREADY=1, OKAY, HRDATA=0 (lowest-index rule for multi-hot).

Decomposition:
- Package ahb_pkg:
  - htrans_t enum (IDLE, BUSY, NONSEQ, SEQ).
  - hresp_t enum (OKAY, ERROR, RETRY, SPLIT).
  - localparam AHB_NUM_SLV=5.
  - default_st_t enum (OK, ERR1, ERR2).
- One sub-module, ahb_default_slave:
  - Holds the two-cycle ERROR FSM.
  - Inputs: HCLK, HRESET, active (invalid DSEL & dtrans).
  - Outputs: ds_hready, ds_hresp.
  - Instantiated only under AHB_DEFAULT_SLV_EN.

Test Plan:
- Reset with all slaves driving HRDATA_S=32'hDEADBEEF -> HRDATA=0, HREADY=1, HRESP=OKAY, DSEL=0; hold HRESET high mid-transfer, same values next cycle.
- HSEL=5'b00100, HTRANS=NONSEQ, HREADY=1 at edge N; slave 2 drives 32'h12345678, HREADYOUT=1 -> cycle N+1 HRDATA=32'h12345678, DSEL=5'b00100, HRESP=OKAY.
- Slave 3 selected; HREADYOUT_S[3]=0 for 2 cycles while HSEL switches to 5'b00001 -> DSEL stays 5'b01000 for both cycles, HREADY=0; switches to 5'b00001 the cycle after slave 3 returns ready.
- Back-to-back NONSEQ/SEQ: HSEL 5'b00001 then 5'b10000 on consecutive ready cycles -> HRDATA follows slave 0 then slave 4 with no idle cycle.
- (AHB_DEFAULT_SLV_EN) HSEL=5'b00000, HTRANS=NONSEQ -> next cycle HREADY=0/HRESP=01, following cycle HREADY=1/HRESP=01, then OKAY; repeat with HTRANS=IDLE -> HREADY=1/OKAY, no ERROR.
- (AHB_DEFAULT_SLV_EN) HSEL=5'b00011, HTRANS=SEQ -> two-cycle ERROR; macro undefined -> slave 0 data routed, OKAY.
